// File: rtl/mem_request_arbiter.sv
// Single-port RAM arbiter serving instruction fetches and data loads/stores with fair priority,
// timeout recovery and one-cycle hit pulses. Define MEM_ARB_PERF_EN to add performance counters.
module mem_request_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic [31:0] iload,
    output logic        ihit,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] stallcount
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        PRIO_INSTR = 1'b0,
        PRIO_DATA  = 1'b1
    } prio_t;

    // Last access cycle before giving up: the counter would reach TIMEOUT on this edge.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    prio_t       prio_q, prio_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dwr_q, dwr_d;
    logic        ramren_q, ramren_d;
    logic        ramwen_q, ramwen_d;
    logic [31:0] ramaddr_q, ramaddr_d;
    logic [31:0] ramstore_q, ramstore_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        ihit_q, ihit_d;
    logic        dhit_q, dhit_d;
    logic        err_q, err_d;

    logic        d_pend;
    logic        timed_out;
    logic [31:0] rdata;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        dwr_d      = dwr_q;
        ramren_d   = ramren_q;
        ramwen_d   = ramwen_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        err_d      = 1'b0;

        d_pend    = dREN | dWEN;
        timed_out = (cnt_q == CNT_LAST);
        rdata     = ramready ? ramload : ERR_WORD;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (d_pend && (prio_q == PRIO_DATA || !iREN)) begin
                    // A simultaneous read+write request is flagged and executed as a store.
                    state_d    = DACC;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    dwr_d      = dWEN;
                    ramwen_d   = dWEN;
                    ramren_d   = ~dWEN;
                    err_d      = dREN & dWEN;
                end else if (iREN) begin
                    state_d   = IACC;
                    ramaddr_d = iaddr;
                    dwr_d     = 1'b0;
                    ramren_d  = 1'b1;
                    ramwen_d  = 1'b0;
                end
            end
            IACC, DACC: begin
                cnt_d = cnt_q + 8'd1;
                if (ramready || timed_out) begin
                    state_d  = DONE;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    err_d    = ~ramready;
                    if (state_q == IACC) begin
                        ihit_d  = 1'b1;
                        iload_d = rdata;
                        prio_d  = PRIO_DATA;
                    end else begin
                        dhit_d = 1'b1;
                        if (!dwr_q) begin
                            dload_d = rdata;
                        end
                        prio_d = PRIO_INSTR;
                    end
                end
            end
            DONE: begin
                // Requesters advance on this edge, so their inputs are not sampled here.
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            prio_q     <= PRIO_DATA;
            cnt_q      <= 8'd0;
            dwr_q      <= 1'b0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= 32'd0;
            ramstore_q <= 32'd0;
            iload_q    <= 32'd0;
            dload_q    <= 32'd0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            dwr_q      <= dwr_d;
            ramren_q   <= ramren_d;
            ramwen_q   <= ramwen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            err_q      <= err_d;
        end
    end

    assign iload    = iload_q;
    assign ihit     = ihit_q;
    assign dload    = dload_q;
    assign dhit     = dhit_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign err      = err_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] icount_q, icount_d;
    logic [31:0] dcount_q, dcount_d;
    logic [31:0] stall_q, stall_d;

    // Counters update on the same edge as the hit they count, so they read current during DONE.
    always_comb begin
        icount_d = icount_q;
        dcount_d = dcount_q;
        stall_d  = stall_q;
        if (ihit_d && icount_q != 32'hFFFF_FFFF) begin
            icount_d = icount_q + 32'd1;
        end
        if (dhit_d && dcount_q != 32'hFFFF_FFFF) begin
            dcount_d = dcount_q + 32'd1;
        end
        if ((iREN | dREN | dWEN) && state_q != DONE && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount_q <= 32'd0;
            dcount_q <= 32'd0;
            stall_q  <= 32'd0;
        end else begin
            icount_q <= icount_d;
            dcount_q <= dcount_d;
            stall_q  <= stall_d;
        end
    end

    assign icount     = icount_q;
    assign dcount     = dcount_q;
    assign stallcount = stall_q;
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, RAM handshake and returned data.
module tb_mem_request_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic        ramready;
    logic [31:0] iload;
    logic        ihit;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        err;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] icount;
    logic [31:0] dcount;
    logic [31:0] stallcount;
`endif

    localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          prio_data;   // model: data side wins a simultaneous request
    logic [31:0] m_dload;     // model: last value returned on dload

    mem_request_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramload(ramload), .ramready(ramready),
        .iload(iload), .ihit(ihit), .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .err(err)
`ifdef MEM_ARB_PERF_EN
        , .icount(icount), .dcount(dcount), .stallcount(stallcount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One access as seen from the requester and RAM sides. Inputs must be set by the caller;
    // from_done=1 means the caller is at the negedge of the DONE cycle of the previous access.
    task automatic run_txn(input bit from_done, input int delay, input logic [31:0] rload,
                           input bit drop_mid, output bit was_d);
        bit          ipend, dpend, grant_d, is_wr, dual;
        logic [31:0] addr, store, exp_data;
        logic        exp_ren, exp_wen, exp_err;
        if (from_done) begin
            @(negedge CLK);
            ramready = 1'b0;
            n_checks++;
            if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
                n_errors++;
                $display("FAIL idle_gap: got ihit/dhit/ren/wen=%b required 0000", {ihit, dhit, ramREN, ramWEN});
            end
        end
        ipend   = iREN;
        dpend   = dREN | dWEN;
        grant_d = dpend && (prio_data || !ipend);
        is_wr   = grant_d && dWEN;
        dual    = grant_d && dREN && dWEN;
        addr    = grant_d ? daddr : iaddr;
        store   = dstore;
        for (int k = 1; k <= delay; k++) begin
            @(negedge CLK);
            exp_ren = !is_wr;
            exp_wen = is_wr;
            exp_err = (k == 1) && dual;
            n_checks++;
            if (ramREN !== exp_ren || ramWEN !== exp_wen) begin
                n_errors++;
                $display("FAIL strobe: cycle %0d got ren/wen=%b%b required %b%b", k, ramREN, ramWEN, exp_ren, exp_wen);
            end
            n_checks++;
            if (ramaddr !== addr) begin
                n_errors++;
                $display("FAIL ramaddr: cycle %0d got %h required %h", k, ramaddr, addr);
            end
            if (is_wr) begin
                n_checks++;
                if (ramstore !== store) begin
                    n_errors++;
                    $display("FAIL ramstore: got %h required %h", ramstore, store);
                end
            end
            n_checks++;
            if (ihit !== 1'b0 || dhit !== 1'b0 || err !== exp_err) begin
                n_errors++;
                $display("FAIL access_flags: cycle %0d got ihit=%b dhit=%b err=%b required 0 0 %b", k, ihit, dhit, err, exp_err);
            end
            if (k == 1) begin
                iaddr  = $urandom;
                daddr  = $urandom;
                dstore = $urandom;
                if (drop_mid) begin
                    if (grant_d) begin
                        dREN = 1'b0;
                        dWEN = 1'b0;
                    end else begin
                        iREN = 1'b0;
                    end
                end
            end
            ramready = (k == delay);
            ramload  = (k == delay) ? rload : 32'($urandom);
        end
        @(negedge CLK);
        ramready = 1'($urandom_range(0, 1));
        ramload  = $urandom;
        n_checks++;
        if (ihit !== !grant_d || dhit !== grant_d) begin
            n_errors++;
            $display("FAIL hit: got ihit=%b dhit=%b required %b %b", ihit, dhit, !grant_d, grant_d);
        end
        n_checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL done_flags: got ren=%b wen=%b err=%b required 0 0 0", ramREN, ramWEN, err);
        end
        if (grant_d) begin
            exp_data = is_wr ? m_dload : rload;
            n_checks++;
            if (dload !== exp_data) begin
                n_errors++;
                $display("FAIL dload: got %h required %h", dload, exp_data);
            end
            m_dload = exp_data;
        end else begin
            n_checks++;
            if (iload !== rload) begin
                n_errors++;
                $display("FAIL iload: got %h required %h", iload, rload);
            end
        end
        prio_data = !grant_d;
        was_d     = grant_d;
        $display("txn %s%s addr=%h delay=%0d", grant_d ? "D" : "I", is_wr ? "W" : "R", addr, delay);
    endtask

    task automatic apply_reset();
        nRST     = 1'b0;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = 32'd0;
        daddr    = 32'd0;
        dstore   = 32'd0;
        ramload  = 32'd0;
        ramready = 1'b0;
        repeat (3) @(negedge CLK);
        nRST      = 1'b1;
        prio_data = 1'b1;
        m_dload   = 32'd0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        iREN = 1'b1;
        dREN = 1'b1;
        dWEN = 1'b0;
        iaddr = 32'h1234; daddr = 32'h5678; dstore = 32'h9; ramload = 32'h1; ramready = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0 || ramaddr !== 32'd0 || ramstore !== 32'd0
            || iload !== 32'd0 || dload !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_held: got flags=%b ramaddr=%h iload=%h dload=%h required all zero",
                     {ihit, dhit, ramREN, ramWEN, err}, ramaddr, iload, dload);
        end
        apply_reset();
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got flags=%b required 00000", {ihit, dhit, ramREN, ramWEN, err});
        end
    endtask

    task automatic test_fetch();
        bit wd;
        iREN  = 1'b1;
        iaddr = 32'h40;
        run_txn(1'b0, 3, 32'h8C010004, 1'b0, wd);
        n_checks++;
        if (wd !== 1'b0 || iload !== 32'h8C010004) begin
            n_errors++;
            $display("FAIL fetch: got grant_d=%b iload=%h required 0 8c010004", wd, iload);
        end
        iREN = 1'b0;
        @(negedge CLK);
        ramready = 1'b0;
        n_checks++;
        if (ihit !== 1'b0 || ramREN !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_after: got ihit=%b ramREN=%b required 0 0", ihit, ramREN);
        end
    endtask

    task automatic test_priority();
        bit wd;
        apply_reset();
        iREN   = 1'b1;
        iaddr  = 32'h80;
        dWEN   = 1'b1;
        daddr  = 32'h100;
        dstore = 32'hDEADBEEF;
        run_txn(1'b0, 2, 32'h0, 1'b0, wd);
        n_checks++;
        if (wd !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_first: got grant_d=%b required 1", wd);
        end
        dWEN = 1'b0;
        run_txn(1'b1, 1, 32'h11112222, 1'b0, wd);
        n_checks++;
        if (wd !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_second: got grant_d=%b required 0", wd);
        end
        iREN = 1'b0;
        @(negedge CLK);
        ramready = 1'b0;
`ifdef MEM_ARB_PERF_EN
        n_checks++;
        if (icount !== 32'd1 || dcount !== 32'd1) begin
            n_errors++;
            $display("FAIL perf_counts: got icount=%0d dcount=%0d required 1 1", icount, dcount);
        end
`endif
    endtask

    task automatic test_alternate();
        bit wd;
        bit exp_seq [4];
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        iREN  = 1'b1;
        dREN  = 1'b1;
        dWEN  = 1'b0;
        iaddr = $urandom;
        daddr = $urandom;
        for (int t = 0; t < 4; t++) begin
            run_txn(t != 0, $urandom_range(1, 3), $urandom, 1'b0, wd);
            n_checks++;
            if (wd !== exp_seq[t]) begin
                n_errors++;
                $display("FAIL alternate: txn %0d got grant_d=%b required %b", t, wd, exp_seq[t]);
            end
        end
    endtask

    task automatic test_dual();
        bit wd;
        iREN   = 1'b0;
        dREN   = 1'b1;
        dWEN   = 1'b1;
        daddr  = 32'h2C0;
        dstore = 32'hCAFEF00D;
        run_txn(1'b1, 2, 32'h77777777, 1'b0, wd);
        n_checks++;
        if (wd !== 1'b1 || dload !== m_dload) begin
            n_errors++;
            $display("FAIL dual: got grant_d=%b dload=%h required 1 %h", wd, dload, m_dload);
        end
    endtask

    task automatic test_timeout();
        int bad;
        iREN     = 1'b0;
        dWEN     = 1'b0;
        dREN     = 1'b1;
        daddr    = 32'h200;
        ramready = 1'b0;
        bad      = 0;
        @(negedge CLK);
        for (int k = 1; k <= 255; k++) begin
            @(negedge CLK);
            if (dhit !== 1'b0 || ramREN !== 1'b1 || err !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL timeout_wait: got %0d bad cycles of 255 required 0", bad);
        end
        @(negedge CLK);
        n_checks++;
        if (dhit !== 1'b1 || err !== 1'b1 || dload !== ERR_WORD || ramREN !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_done: got dhit=%b err=%b dload=%h ren=%b required 1 1 %h 0",
                     dhit, err, dload, ramREN, ERR_WORD);
        end
        dREN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (dhit !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_after: got dhit=%b err=%b required 0 0", dhit, err);
        end
        prio_data = 1'b0;
        m_dload   = ERR_WORD;
        $display("txn DR addr=00000200 timeout");
    endtask

    task automatic test_reset_mid();
        bit wd;
        int bad;
        @(negedge CLK);
        dREN  = 1'b1;
        daddr = 32'h300;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (ramREN !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_pre: got ramREN=%b required 1", ramREN);
        end
        #2 nRST = 1'b0;
        #1;
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0 || ramaddr !== 32'd0 || dload !== 32'd0 || iload !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_async: got flags=%b ramaddr=%h dload=%h required all zero",
                     {ihit, dhit, ramREN, ramWEN, err}, ramaddr, dload);
        end
        dREN     = 1'b0;
        ramready = 1'b1;
        bad      = 0;
        repeat (2) begin
            @(negedge CLK);
            if (dhit !== 1'b0) bad++;
        end
        ramready  = 1'b0;
        nRST      = 1'b1;
        prio_data = 1'b1;
        m_dload   = 32'd0;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL reset_nohit: got %0d hits required 0", bad);
        end
        dREN  = 1'b1;
        daddr = $urandom;
        run_txn(1'b0, 2, $urandom, 1'b0, wd);
        n_checks++;
        if (wd !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_resume: got grant_d=%b required 1", wd);
        end
        dREN = 1'b0;
    endtask

    task automatic test_random();
        bit wd;
        int r;
        iREN  = 1'($urandom_range(0, 1));
        dREN  = 1'b1;
        daddr = $urandom;
        for (int t = 0; t < 40; t++) begin
            run_txn(1'b1, $urandom_range(1, 5), $urandom, $urandom_range(0, 3) == 0, wd);
            if (wd) begin
                r    = $urandom_range(0, 7);
                dREN = (r == 1 || r == 2 || r == 3 || r == 7);
                dWEN = (r == 4 || r == 5 || r == 7);
            end else begin
                iREN = 1'($urandom_range(0, 1));
            end
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            if (!iREN && !dREN && !dWEN) iREN = 1'b1;
        end
    endtask

    initial begin
        prio_data = 1'b1;
        m_dload   = 32'd0;
        test_reset();
        test_fetch();
        test_priority();
        test_alternate();
        test_dual();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
